// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and constants for the program loader.
// State encoding, error codes and RAM geometry.
package prog_load_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_WIDTH = 16;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_CHK     = 3'd4,
    ST_RUN     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LEN_ZERO = 2'd1;
  localparam logic [1:0] ERR_CHK      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // States in which a frame is in flight and the idle timer runs.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA_LO) ||
           (s == ST_DATA_HI) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_load_timeout.sv
// Restartable down-counter for inter-byte idle time.
// Reloads on clear or when disabled; expire is combinational.
module prog_load_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Last idle cycle of the budget; a clear in the same cycle wins.
  assign expire = enable && !clear && (cnt == W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= W'(TIMEOUT);
    end else if (clear || !enable) begin
      cnt <= W'(TIMEOUT);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Framed program loader: parses UART bytes into the 256x16 RAM,
// verifies the checksum, then hands the RAM port to the CPU.
import prog_load_ctrl_pkg::*;

module prog_load_ctrl #(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic [RAM_AW-1:0]    pc_addr,
  input  logic                 halt_req,
  output logic                 ram_we,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  output logic                 cpu_run,
  output logic                 load_done,
  output logic                 load_err,
  output logic [1:0]           err_code
);

  state_t state, state_d;

  logic [7:0]           n_words, n_words_d;
  logic [RAM_AW-1:0]    idx, idx_d;
  logic [7:0]           lo, lo_d;
  logic [7:0]           sum, sum_d;
  logic                 we_q, we_d;
  logic [RAM_AW-1:0]    wr_addr, wr_addr_d;
  logic [RAM_WIDTH-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 expire;

  prog_load_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (in_frame(state)),
    .expire (expire)
  );

  always_comb begin
    state_d   = state;
    n_words_d = n_words;
    idx_d     = idx;
    lo_d      = lo;
    sum_d     = sum;
    we_d      = 1'b0;
    wr_addr_d = wr_addr;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    err_d     = err_q;
    code_d    = code_q;

    if (expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = ST_LEN;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'd0) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_LEN_ZERO;
            end else begin
              n_words_d = rx_data;
              sum_d     = rx_data;
              idx_d     = '0;
              state_d   = ST_DATA_LO;
            end
          end
        end
        ST_DATA_LO: begin
          if (rx_valid) begin
            lo_d    = rx_data;
            sum_d   = sum + rx_data;
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (rx_valid) begin
            we_d      = 1'b1;
            wr_addr_d = idx;
            wdata_d   = {rx_data, lo};
            sum_d     = sum + rx_data;
            idx_d     = idx + 8'd1;
            state_d   = (idx == n_words - 8'd1) ? ST_CHK : ST_DATA_LO;
          end
        end
        ST_CHK: begin
          if (rx_valid) begin
            if (rx_data == sum) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_CHK;
            end
          end
        end
        ST_RUN: begin
          // Halt takes priority; any byte in this cycle is dropped.
          if (halt_req) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      n_words <= '0;
      idx     <= '0;
      lo      <= '0;
      sum     <= '0;
      we_q    <= 1'b0;
      wr_addr <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state   <= state_d;
      n_words <= n_words_d;
      idx     <= idx_d;
      lo      <= lo_d;
      sum     <= sum_d;
      we_q    <= we_d;
      wr_addr <= wr_addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign cpu_run   = (state == ST_RUN);
  assign ram_we    = we_q && !cpu_run;
  assign ram_addr  = cpu_run ? pc_addr : wr_addr;
  assign ram_wdata = wdata_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Scoreboard bench for prog_load_ctrl: frame-level model pushes
// expected writes/outcomes, a monitor pops them as the DUT emits.
module tb_prog_load_ctrl;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  pc_addr = '0;
  logic        halt_req = 1'b0;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  prog_load_ctrl #(
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pc_addr   (pc_addr),
    .halt_req  (halt_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_run   (cpu_run),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t wq[$];
  int  eq[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit hn);
    repeat (gap) begin
      halt_req = hn && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    halt_req = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((wq.size() != 0 || eq.size() != 0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (wq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL drain pending_writes=%0d pending_events=%0d required=0",
               wq.size(), eq.size());
      wq.delete();
      eq.delete();
    end
    idle(2);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    halt_req = 1'b0;
    idle(2);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_err_code", err_code, 0);
    reset = 1'b0;
    idle(1);
  endtask

  // Modes: 0 good, 2 bad checksum, 4 truncated after cut data bytes.
  task automatic frame(input int n, input int mode, input int cut,
                       input int maxgap, input bit hn);
    int s = n;
    int db = 0;
    logic [7:0] lo, hi, c;
    send(8'hA5, $urandom_range(0, maxgap), hn);
    if (n == 0) eq.push_back(1);
    send(8'(n), $urandom_range(0, maxgap), hn);
    if (n == 0) return;
    for (int w = 0; w < n; w++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      if (mode == 4 && db >= cut) break;
      send(lo, $urandom_range(0, maxgap), hn);
      db++;
      s += lo;
      if (mode == 4 && db >= cut) break;
      wq.push_back('{a: 8'(w), d: {hi, lo}});
      send(hi, $urandom_range(0, maxgap), hn);
      db++;
      s += hi;
    end
    if (mode == 4) begin
      eq.push_back(3);
      idle(TO + 5);
      return;
    end
    c = 8'(s % 256);
    if (mode == 2) c = c + 8'd1 + 8'($urandom_range(0, 254));
    eq.push_back(mode == 2 ? 2 : 0);
    send(c, $urandom_range(0, maxgap), hn);
  endtask

  task automatic run_phase(input bit with_byte);
    logic [7:0] pa;
    chk("run_cpu_run", cpu_run, 1);
    chk("run_err_code", err_code, 0);
    pa = 8'($urandom);
    pc_addr = pa;
    #1;
    chk("run_ram_addr", ram_addr, pa);
    for (int i = 0; i < 3; i++) send(8'($urandom), $urandom_range(0, 2), 0);
    send(8'hA5, 0, 0);
    send(8'h00, 0, 0);
    chk("run_still", cpu_run, 1);
    halt_req = 1'b1;
    rx_data  = 8'hA5;
    rx_valid = with_byte;
    @(posedge clk);
    #1;
    halt_req = 1'b0;
    rx_valid = 1'b0;
    chk("halt_cpu_run", cpu_run, 0);
    // A swallowed A5 would turn this 00 into a zero-length error.
    send(8'h00, 1, 0);
    idle(2);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    wr_t w;
    int  e;
    bit  prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_err = 1'b0;
      end else begin
        if (ram_we) begin
          if (wq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0h data=%0h required none",
                     ram_addr, ram_wdata);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", ram_addr, w.a);
            chk("wr_data", ram_wdata, w.d);
          end
          chk("we_while_run", cpu_run, 0);
        end
        if (load_done) begin
          if (eq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required none");
          end else begin
            e = eq.pop_front();
            chk("done_event", 0, e);
            chk("done_cpu_run", cpu_run, 1);
            chk("done_load_err", load_err, 0);
          end
        end
        if (load_err && !prev_err) begin
          if (eq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_err actual=%0d required none", err_code);
          end else begin
            e = eq.pop_front();
            chk("err_code", err_code, e);
            chk("err_cpu_run", cpu_run, 0);
          end
        end
        prev_err = load_err;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, n;
    do_reset();

    // Directed good frame.
    wq.push_back('{a: 8'h00, d: 16'h1234});
    send(8'hA5, 0, 0);
    send(8'h02, 0, 0);
    send(8'h34, 0, 0);
    send(8'h12, 0, 0);
    wq.push_back('{a: 8'h01, d: 16'h5678});
    send(8'h78, 0, 0);
    send(8'h56, 0, 0);
    eq.push_back(0);
    send(8'h16, 0, 0);
    drain(10);
    run_phase(1'b1);

    // Bad checksum, then A5 clears the error.
    send(8'hA5, 0, 0);
    send(8'h01, 0, 0);
    send(8'hAA, 0, 0);
    wq.push_back('{a: 8'h00, d: 16'hBBAA});
    send(8'hBB, 0, 0);
    eq.push_back(2);
    send(8'h00, 0, 0);
    drain(10);
    chk("chk_err_flag", load_err, 1);
    send(8'hA5, 0, 0);
    chk("sync_clears_err", load_err, 0);
    chk("sync_clears_code", err_code, 0);

    // Zero length (already past SYNC).
    eq.push_back(1);
    send(8'h00, 0, 0);
    drain(10);

    // Timeout after A5,03,11.
    send(8'hA5, 0, 0);
    send(8'h03, 0, 0);
    send(8'h11, 0, 0);
    eq.push_back(3);
    idle(TO - 1);
    chk("timeout_not_yet", load_err, 0);
    drain(10);
    chk("timeout_code", err_code, 3);

    // Byte on the expiry cycle suppresses the timeout.
    send(8'hA5, 0, 0);
    send(8'h03, 0, 0);
    send(8'h11, 0, 0);
    wq.push_back('{a: 8'h00, d: 16'h2211});
    send(8'h22, TO - 1, 0);
    send(8'h33, TO - 1, 0);
    wq.push_back('{a: 8'h01, d: 16'h4433});
    send(8'h44, 0, 0);
    send(8'h55, 0, 0);
    wq.push_back('{a: 8'h02, d: 16'h6655});
    send(8'h66, 0, 0);
    eq.push_back(0);
    send(8'((3 + 8'h11 + 8'h22 + 8'h33 + 8'h44 + 8'h55 + 8'h66) % 256),
         TO - 1, 0);
    drain(10);
    run_phase(1'b0);

    // Reset mid-frame.
    send(8'hA5, 0, 0);
    send(8'h02, 0, 0);
    send(8'h01, 0, 0);
    do_reset();
    idle(3);
    frame(2, 0, 0, 1, 0);
    drain(10);
    run_phase(1'b0);

    // Longest frame, addresses 0..254.
    frame(255, 0, 0, 0, 0);
    drain(10);
    run_phase(1'b1);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send(nb, $urandom_range(0, 2), 1);
      end
      mode = $urandom_range(0, 4);
      n = $urandom_range(1, 8);
      case (mode)
        0, 1: begin
          frame(n, 0, 0, 3, 1);
          drain(10);
          run_phase(1'($urandom_range(0, 1)));
        end
        2: begin
          frame(n, 2, 0, 3, 1);
          drain(10);
        end
        3: begin
          frame(0, 0, 0, 3, 1);
          drain(10);
        end
        default: begin
          frame(n, 4, $urandom_range(0, 2 * n), 3, 1);
          drain(TO + 10);
        end
      endcase
    end

    drain(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
